// File: rtl/instr_type.sv
// Shared RV32I encoder types: opcode kinds, format classes, 7-bit opcodes and shift funct3 codes.
package instr_type;

    typedef enum logic [3:0] {
        lui,
        auipc,
        jal,
        jalr,
        branch_type,
        load_type,
        store_type,
        imm_arith_type,
        reg_arith_type,
        fence_type,
        system_type,
        invalid
    } opcode_t;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } format_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/encode_opcode.sv
// Combinational map from opcode kind to the 7-bit major opcode and its format class.
module encode_opcode
    import instr_type::*;
(
    input  opcode_t     kind,
    output logic [6:0]  opcode,
    output format_t     fmt
);

    always_comb begin
        opcode = 7'b0;
        fmt    = FMT_NONE;
        case (kind)
            lui:            begin opcode = OP_LUI;    fmt = FMT_U; end
            auipc:          begin opcode = OP_AUIPC;  fmt = FMT_U; end
            jal:            begin opcode = OP_JAL;    fmt = FMT_J; end
            jalr:           begin opcode = OP_JALR;   fmt = FMT_I; end
            branch_type:    begin opcode = OP_BRANCH; fmt = FMT_B; end
            load_type:      begin opcode = OP_LOAD;   fmt = FMT_I; end
            store_type:     begin opcode = OP_STORE;  fmt = FMT_S; end
            imm_arith_type: begin opcode = OP_IMM;    fmt = FMT_I; end
            reg_arith_type: begin opcode = OP_REG;    fmt = FMT_R; end
            fence_type:     begin opcode = OP_FENCE;  fmt = FMT_I; end
            system_type:    begin opcode = OP_SYSTEM; fmt = FMT_I; end
            default:        begin opcode = 7'b0;      fmt = FMT_NONE; end
        endcase
    end

endmodule

// File: rtl/encode_instr.sv
// Two-stage valid/ready RV32I instruction encoder (fields in, packed word out).
// Optional immediate range checking is enabled with `define ENCODE_RANGE_CHECK_EN.
module encode_instr
    import instr_type::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  opcode_t          in_type,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [XLEN-1:0]  in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic             out_err
);

    logic [6:0]      op_next;
    format_t         fmt_next;
    logic            shift_next;
    logic            range_err;

    logic            rdy_reg;
    logic            s1_valid_reg;
    logic [6:0]      s1_op_reg;
    format_t         s1_fmt_reg;
    logic            s1_shift_reg;
    logic [4:0]      s1_rd_reg;
    logic [4:0]      s1_rs1_reg;
    logic [4:0]      s1_rs2_reg;
    logic [2:0]      s1_f3_reg;
    logic [6:0]      s1_f7_reg;
    logic [XLEN-1:0] s1_imm_reg;
    logic            s1_err_reg;

    logic            s2_valid_reg;
    logic [XLEN-1:0] s2_instr_reg;
    logic            s2_err_reg;
    logic [XLEN-1:0] pack_next;

    logic            s1_load;
    logic            s2_load;

    encode_opcode u_opcode (
        .kind   (in_type),
        .opcode (op_next),
        .fmt    (fmt_next)
    );

    assign shift_next = (in_type == imm_arith_type) &&
                        ((in_funct3 == F3_SLL) || (in_funct3 == F3_SR));

`ifdef ENCODE_RANGE_CHECK_EN
    logic signed [XLEN-1:0] imm_s;
    assign imm_s = $signed(in_imm);

    always_comb begin
        range_err = 1'b0;
        case (fmt_next)
            FMT_I, FMT_S: begin
                if (shift_next)
                    range_err = (in_imm > 32'd31);
                else
                    range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            FMT_B: range_err = in_imm[0] || (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
            FMT_J: range_err = in_imm[0] || (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
            FMT_U: range_err = (in_imm[11:0] != 12'd0);
            default: range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // A stage may load when it is empty or its occupant leaves this cycle.
    assign s2_load   = !s2_valid_reg || out_ready;
    assign s1_load   = !s1_valid_reg || s2_load;
    assign in_ready  = rdy_reg && s1_load;

    always_comb begin
        pack_next = '0;
        case (s1_fmt_reg)
            FMT_R: pack_next = {s1_f7_reg, s1_rs2_reg, s1_rs1_reg, s1_f3_reg, s1_rd_reg, s1_op_reg};
            FMT_I: begin
                if (s1_shift_reg)
                    pack_next = {s1_f7_reg, s1_imm_reg[4:0], s1_rs1_reg, s1_f3_reg, s1_rd_reg, s1_op_reg};
                else
                    pack_next = {s1_imm_reg[11:0], s1_rs1_reg, s1_f3_reg, s1_rd_reg, s1_op_reg};
            end
            FMT_S: pack_next = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg, s1_f3_reg,
                                s1_imm_reg[4:0], s1_op_reg};
            FMT_B: pack_next = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg, s1_rs1_reg, s1_f3_reg,
                                s1_imm_reg[4:1], s1_imm_reg[11], s1_op_reg};
            FMT_U: pack_next = {s1_imm_reg[31:12], s1_rd_reg, s1_op_reg};
            FMT_J: pack_next = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                                s1_imm_reg[19:12], s1_rd_reg, s1_op_reg};
            default: pack_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_reg      <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= 7'b0;
            s1_fmt_reg   <= FMT_NONE;
            s1_shift_reg <= 1'b0;
            s1_rd_reg    <= 5'b0;
            s1_rs1_reg   <= 5'b0;
            s1_rs2_reg   <= 5'b0;
            s1_f3_reg    <= 3'b0;
            s1_f7_reg    <= 7'b0;
            s1_imm_reg   <= '0;
            s1_err_reg   <= 1'b0;
            s2_valid_reg <= 1'b0;
            s2_instr_reg <= '0;
            s2_err_reg   <= 1'b0;
        end else begin
            rdy_reg <= 1'b1;
            if (s1_load) begin
                s1_valid_reg <= in_valid && rdy_reg;
                if (in_valid && rdy_reg) begin
                    s1_op_reg    <= op_next;
                    s1_fmt_reg   <= fmt_next;
                    s1_shift_reg <= shift_next;
                    s1_rd_reg    <= in_rd;
                    s1_rs1_reg   <= in_rs1;
                    s1_rs2_reg   <= in_rs2;
                    s1_f3_reg    <= (in_type == jalr) ? 3'b000 : in_funct3;
                    s1_f7_reg    <= in_funct7;
                    s1_imm_reg   <= in_imm;
                    s1_err_reg   <= (fmt_next == FMT_NONE) || range_err;
                end
            end
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_instr_reg <= pack_next;
                    s2_err_reg   <= s1_err_reg;
                end
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_instr = s2_instr_reg;
    assign out_err   = s2_err_reg;

endmodule

// File: doc/encode_instr.md
Name: encode_instr

Overview:
- RV32I instruction encoder: the inverse of the opcode decode path.
- Takes an opcode kind plus register, funct and immediate fields; emits the packed 32-bit instruction word.
- Two-stage valid/ready pipeline.
- Used by the self-test instruction generator and the boot-ROM builder to feed the fetch/decode path.

Parameters:
- XLEN, 32, instruction/immediate width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept this cycle
- in_type  in  opcode_t  opcode kind (lui … system_type, invalid)
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field; R-type and shift-immediates only
- in_imm  in  32  immediate as a full signed byte value
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction
- out_err  out  1  word flagged as unencodable

Behaviour:
- Reset: rst low clears both stage valids immediately (asynchronous). While held:
  - out_valid=0, out_instr=0, out_err=0
  - in_ready=0 while rst low; in_ready=1 from the first clock after release
- Reset mid-operation: in-flight words are dropped, never emitted.
- Handshake:
  - Transfer occurs on a rising edge with valid&&ready.
  - Each stage loads when it is empty or its downstream accepts.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - Throughput 1 word/cycle; latency 2 cycles from input transfer to out_valid when unstalled.
  - out_instr/out_err hold stable while out_valid&&!out_ready. No word is lost or duplicated; order is preserved.
- Stage 1: registers fields and opcode bits, plus the range-check result when the optional feature is on.
- Stage 2: packs the format into the output register.
- Formats (op = 7-bit opcode of in_type):
  - reg_arith_type (R): funct7|rs2|rs1|funct3|rd|op
  - jalr, load_type, fence_type, system_type, imm_arith_type (I): imm[11:0]|rs1|funct3|rd|op
    - jalr forces funct3=000.
    - imm_arith with funct3 001/101 (shifts): funct7|imm[4:0]|rs1|funct3|rd|op
  - store_type (S): imm[11:5]|rs2|rs1|funct3|imm[4:0]|op
  - branch_type (B): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op
  - lui, auipc (U): imm[31:12]|rd|op
  - jal (J): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - invalid: out_instr=0, out_err=1
- Fields unused by a format are ignored; the immediate is truncated to the format width.

Optional Feature:
- Macro: ENCODE_RANGE_CHECK_EN
- Defined: out_err=1 additionally when any of these hold (the word is still packed by truncation):
  - I/S imm not in [-2048,2047]
  - shift imm not in [0,31]
  - B imm not even or not in [-4096,4094]
  - J imm not even or not in [-1048576,1048574]
  - U imm[11:0]!=0
- Undefined: out_err only for invalid type; no range logic is synthesised.

Decomposition:
- instr_type package:
  - existing opcode_t
  - new localparams for the 7-bit opcode constants (OP_LUI … OP_SYSTEM)
  - funct3 constants for shifts (F3_SLL=001, F3_SR=101)
- Sub-module encode_opcode: combinational opcode_t -> 7-bit opcode, plus a format-class enum (R/I/S/B/U/J/NONE).
- The format-class enum lives in instr_type as format_t.

Test Plan:
- addi x1,x0,5 (imm_arith_type, rd=1, rs1=0, f3=0, imm=5), out_ready=1 -> out_instr=0x00500093, out_err=0, out_valid exactly 2 cycles after transfer.
- add x3,x1,x2 back-to-back with beq x1,x2,-8 (branch_type, rs1=1, rs2=2, imm=-8) -> consecutive cycles 0x002081B3 then 0xFE208CE3.
- jal x1,2048 -> 0x001000EF; addi x1,x0,2048:
  - with ENCODE_RANGE_CHECK_EN -> 0x80000093, out_err=1
  - without -> 0x80000093, out_err=0
- in_type=invalid -> out_instr=0x00000000, out_err=1, pipeline continues with the next word.
- Backpressure: hold out_ready=0 while driving 3 valid words.
  - in_ready drops after 2 accepted.
  - out_instr stays stable.
  - On release, 3 words emerge in order with no gaps or duplicates.
- Reset mid-flight: both stages full, pull rst low between edges.
  - out_valid=0 immediately.
  - After release, no stale word appears and in_ready=1 from the next edge.
